// File: rtl/multicycle_control32.sv
// Multi-cycle Minisys main controller: sequences IF/ID/EX/MEM/WB/IOW and drives per-cycle
// datapath strobes, with memory wait states and an I/O ready handshake bounded by a timeout.
module multicycle_control32 #(
  parameter int unsigned             ADDR_HIGH_W = 22,
  parameter logic [ADDR_HIGH_W-1:0]  IO_MATCH    = '1,
  parameter int unsigned             MEM_WAIT    = 1,
  parameter int unsigned             IO_TIMEOUT  = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [5:0]             Opcode,
  input  logic [5:0]             Function_opcode,
  input  logic [ADDR_HIGH_W-1:0] Alu_resultHigh,
  input  logic                   Zero,
  input  logic                   io_ready,
  output logic                   PCWrite,
  output logic [1:0]             PCSrc,
  output logic                   IRWrite,
  output logic                   RegWrite,
  output logic                   RegDST,
  output logic                   ALUSrc,
  output logic                   Sftmd,
  output logic                   Jal,
  output logic                   Jr,
  output logic                   Jmp,
  output logic [1:0]             ALUOp,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IORead,
  output logic                   IOWrite,
  output logic                   MemorIOtoReg,
  output logic                   illegal,
  output logic [2:0]             state
);

  typedef enum logic [2:0] {
    StIf  = 3'd0,
    StId  = 3'd1,
    StEx  = 3'd2,
    StMem = 3'd3,
    StWb  = 3'd4,
    StIow = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    ClsNone, ClsR, ClsI, ClsLw, ClsSw, ClsBeq, ClsBne, ClsJ, ClsJal, ClsJr, ClsBad
  } cls_e;

  localparam logic [2:0]  MemWaitLast = 3'(MEM_WAIT);
  localparam logic [15:0] ToLast      = 16'(IO_TIMEOUT - 1);

  state_e      state_q;
  cls_e        cls_q;
  logic        sftmd_q;
  logic        io_sel_q;
  logic [2:0]  wait_cnt_q;
  logic [15:0] to_cnt_q;

  cls_e dec_cls;
  logic dec_sftmd;
  logic io_match;
  logic io_now;
  logic timeout;

  always_comb begin
    dec_cls = ClsBad;
    if (Opcode == 6'b000000) begin
      dec_cls = (Function_opcode == 6'b001000) ? ClsJr : ClsR;
    end else if (Opcode[5:3] == 3'b001) begin
      dec_cls = ClsI;
    end else begin
      case (Opcode)
        6'b100011: dec_cls = ClsLw;
        6'b101011: dec_cls = ClsSw;
        6'b000100: dec_cls = ClsBeq;
        6'b000101: dec_cls = ClsBne;
        6'b000010: dec_cls = ClsJ;
        6'b000011: dec_cls = ClsJal;
        default:   dec_cls = ClsBad;
      endcase
    end
  end

  assign dec_sftmd = (Opcode == 6'b000000) && (Function_opcode[5:3] == 3'b000);
  assign io_match  = (Alu_resultHigh == IO_MATCH);
  // Only the first MEM cycle sees the live address; later cycles use the latched select.
  assign io_now    = (wait_cnt_q == 3'd0) ? io_match : io_sel_q;
  assign timeout   = (to_cnt_q == ToLast);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIf;
      cls_q      <= ClsNone;
      sftmd_q    <= 1'b0;
      io_sel_q   <= 1'b0;
      wait_cnt_q <= 3'd0;
      to_cnt_q   <= 16'd0;
    end else begin
      case (state_q)
        StIf: state_q <= StId;
        StId: begin
          cls_q   <= dec_cls;
          sftmd_q <= dec_sftmd;
          case (dec_cls)
            ClsJ, ClsJal, ClsJr, ClsBad: state_q <= StIf;
            default:                     state_q <= StEx;
          endcase
        end
        StEx: begin
          case (cls_q)
            ClsBeq, ClsBne: state_q <= StIf;
            ClsLw, ClsSw: begin
              state_q    <= StMem;
              wait_cnt_q <= 3'd0;
            end
            default: state_q <= StWb;
          endcase
        end
        StMem: begin
          if (wait_cnt_q == 3'd0) io_sel_q <= io_match;
          if (io_now) begin
            state_q  <= StIow;
            to_cnt_q <= 16'd0;
          end else if (cls_q == ClsLw) begin
            if (wait_cnt_q == MemWaitLast) state_q <= StWb;
            else wait_cnt_q <= wait_cnt_q + 3'd1;
          end else begin
            state_q <= StIf;
          end
        end
        StIow: begin
          if (io_ready) state_q <= (cls_q == ClsLw) ? StWb : StIf;
          else if (timeout) state_q <= StIf;
          else to_cnt_q <= to_cnt_q + 16'd1;
        end
        StWb:    state_q <= StIf;
        default: state_q <= StIf;
      endcase
    end
  end

  always_comb begin
    PCWrite      = 1'b0;
    PCSrc        = 2'b00;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    RegDST       = 1'b0;
    ALUSrc       = 1'b0;
    Sftmd        = 1'b0;
    Jal          = 1'b0;
    Jr           = 1'b0;
    Jmp          = 1'b0;
    ALUOp        = 2'b00;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IORead       = 1'b0;
    IOWrite      = 1'b0;
    MemorIOtoReg = 1'b0;
    illegal      = 1'b0;
    if (!reset) begin
      case (state_q)
        StIf: begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
        StId: begin
          case (dec_cls)
            ClsJ: begin
              PCWrite = 1'b1;
              PCSrc   = 2'b10;
              Jmp     = 1'b1;
            end
            ClsJal: begin
              PCWrite  = 1'b1;
              PCSrc    = 2'b10;
              RegWrite = 1'b1;
              Jal      = 1'b1;
            end
            ClsJr: begin
              PCWrite = 1'b1;
              PCSrc   = 2'b11;
              Jr      = 1'b1;
            end
            ClsBad:  illegal = 1'b1;
            default: ;
          endcase
        end
        StEx: begin
          ALUSrc = (cls_q == ClsI) || (cls_q == ClsLw) || (cls_q == ClsSw);
          ALUOp  = {(cls_q == ClsR) || (cls_q == ClsI), (cls_q == ClsBeq) || (cls_q == ClsBne)};
          Sftmd  = sftmd_q && (cls_q == ClsR);
          if ((cls_q == ClsBeq) || (cls_q == ClsBne)) begin
            PCSrc   = 2'b01;
            PCWrite = ((cls_q == ClsBeq) && Zero) || ((cls_q == ClsBne) && !Zero);
          end
        end
        StMem: begin
          MemRead  = !io_now && (cls_q == ClsLw);
          MemWrite = !io_now && (cls_q == ClsSw);
        end
        StIow: begin
          IORead  = (cls_q == ClsLw);
          IOWrite = (cls_q == ClsSw);
          illegal = timeout && !io_ready;
        end
        StWb: begin
          RegWrite     = 1'b1;
          RegDST       = (cls_q == ClsR);
          MemorIOtoReg = (cls_q == ClsLw);
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control32.sv
// Directed bench for multicycle_control32: walks instruction classes cycle by cycle and compares
// the state code plus a packed vector of all strobes against hand-derived expectations.
module tb_multicycle_control32;

  logic        clock;
  logic        reset;
  logic [5:0]  Opcode;
  logic [5:0]  Function_opcode;
  logic [21:0] Alu_resultHigh;
  logic        Zero;
  logic        io_ready;
  logic        PCWrite;
  logic [1:0]  PCSrc;
  logic        IRWrite, RegWrite, RegDST, ALUSrc, Sftmd, Jal, Jr, Jmp;
  logic [1:0]  ALUOp;
  logic        MemRead, MemWrite, IORead, IOWrite, MemorIOtoReg, illegal;
  logic [2:0]  state;
  logic [18:0] outs;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [18:0] O_PCW    = 19'(1) << 18;
  localparam logic [18:0] O_SRC_BR = 19'(1) << 16;
  localparam logic [18:0] O_SRC_J  = 19'(2) << 16;
  localparam logic [18:0] O_SRC_JR = 19'(3) << 16;
  localparam logic [18:0] O_IRW    = 19'(1) << 15;
  localparam logic [18:0] O_RW     = 19'(1) << 14;
  localparam logic [18:0] O_RDST   = 19'(1) << 13;
  localparam logic [18:0] O_ASRC   = 19'(1) << 12;
  localparam logic [18:0] O_SFT    = 19'(1) << 11;
  localparam logic [18:0] O_JAL    = 19'(1) << 10;
  localparam logic [18:0] O_JR     = 19'(1) << 9;
  localparam logic [18:0] O_JMP    = 19'(1) << 8;
  localparam logic [18:0] O_AOP_R  = 19'(1) << 7;
  localparam logic [18:0] O_AOP_B  = 19'(1) << 6;
  localparam logic [18:0] O_MR     = 19'(1) << 5;
  localparam logic [18:0] O_MW     = 19'(1) << 4;
  localparam logic [18:0] O_IOR    = 19'(1) << 3;
  localparam logic [18:0] O_IOW    = 19'(1) << 2;
  localparam logic [18:0] O_M2R    = 19'(1) << 1;
  localparam logic [18:0] O_ILL    = 19'(1);
  localparam logic [18:0] O_FETCH  = O_PCW | O_IRW;

  multicycle_control32 #(
    .ADDR_HIGH_W(22),
    .IO_MATCH   (22'h3FFFFF),
    .MEM_WAIT   (1),
    .IO_TIMEOUT (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .Opcode         (Opcode),
    .Function_opcode(Function_opcode),
    .Alu_resultHigh (Alu_resultHigh),
    .Zero           (Zero),
    .io_ready       (io_ready),
    .PCWrite        (PCWrite),
    .PCSrc          (PCSrc),
    .IRWrite        (IRWrite),
    .RegWrite       (RegWrite),
    .RegDST         (RegDST),
    .ALUSrc         (ALUSrc),
    .Sftmd          (Sftmd),
    .Jal            (Jal),
    .Jr             (Jr),
    .Jmp            (Jmp),
    .ALUOp          (ALUOp),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .IORead         (IORead),
    .IOWrite        (IOWrite),
    .MemorIOtoReg   (MemorIOtoReg),
    .illegal        (illegal),
    .state          (state)
  );

  assign outs = {PCWrite, PCSrc, IRWrite, RegWrite, RegDST, ALUSrc, Sftmd, Jal, Jr, Jmp,
                 ALUOp, MemRead, MemWrite, IORead, IOWrite, MemorIOtoReg, illegal};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Checks the current cycle, then advances to just after the next rising edge.
  task automatic cyc(input string tag, input logic [2:0] es, input logic [18:0] eo);
    #1;
    check({tag, ".st"}, 32'(state), 32'(es));
    check({tag, ".o"}, 32'(outs), 32'(eo));
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset           = 1'b1;
    Opcode          = 6'b000000;
    Function_opcode = 6'b100001;
    Alu_resultHigh  = 22'h0;
    Zero            = 1'b0;
    io_ready        = 1'b0;
    #1;
    check("rst.st", 32'(state), 32'd0);
    check("rst.o", 32'(outs), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // addu
    cyc("addu.if", 3'd0, O_FETCH);
    cyc("addu.id", 3'd1, 19'd0);
    cyc("addu.ex", 3'd2, O_AOP_R);
    cyc("addu.wb", 3'd4, O_RW | O_RDST);

    // sll: shift select in EX
    Function_opcode = 6'b000000;
    cyc("sll.if", 3'd0, O_FETCH);
    cyc("sll.id", 3'd1, 19'd0);
    cyc("sll.ex", 3'd2, O_AOP_R | O_SFT);
    cyc("sll.wb", 3'd4, O_RW | O_RDST);

    // addi
    Opcode = 6'b001000;
    cyc("addi.if", 3'd0, O_FETCH);
    cyc("addi.id", 3'd1, 19'd0);
    cyc("addi.ex", 3'd2, O_AOP_R | O_ASRC);
    cyc("addi.wb", 3'd4, O_RW);

    // lw from memory, one wait state
    Opcode = 6'b100011;
    Alu_resultHigh = 22'h0;
    cyc("lwm.if", 3'd0, O_FETCH);
    cyc("lwm.id", 3'd1, 19'd0);
    cyc("lwm.ex", 3'd2, O_ASRC);
    cyc("lwm.mem0", 3'd3, O_MR);
    cyc("lwm.mem1", 3'd3, O_MR);
    cyc("lwm.wb", 3'd4, O_RW | O_M2R);

    // sw to memory
    Opcode = 6'b101011;
    cyc("swm.if", 3'd0, O_FETCH);
    cyc("swm.id", 3'd1, 19'd0);
    cyc("swm.ex", 3'd2, O_ASRC);
    cyc("swm.mem", 3'd3, O_MW);

    // sw to I/O, ready on the third IOW cycle
    Alu_resultHigh = 22'h3FFFFF;
    cyc("swio.if", 3'd0, O_FETCH);
    cyc("swio.id", 3'd1, 19'd0);
    cyc("swio.ex", 3'd2, O_ASRC);
    cyc("swio.mem", 3'd3, 19'd0);
    cyc("swio.iow1", 3'd5, O_IOW);
    cyc("swio.iow2", 3'd5, O_IOW);
    io_ready = 1'b1;
    cyc("swio.iow3", 3'd5, O_IOW);
    io_ready = 1'b0;

    // beq taken
    Opcode = 6'b000100;
    Zero = 1'b1;
    cyc("beq1.if", 3'd0, O_FETCH);
    cyc("beq1.id", 3'd1, 19'd0);
    cyc("beq1.ex", 3'd2, O_AOP_B | O_PCW | O_SRC_BR);

    // beq not taken
    Zero = 1'b0;
    cyc("beq0.if", 3'd0, O_FETCH);
    cyc("beq0.id", 3'd1, 19'd0);
    #1;
    check("beq0.ex.st", 32'(state), 32'd2);
    check("beq0.ex.pcw", 32'(PCWrite), 32'd0);
    check("beq0.ex.aop", 32'(ALUOp), 32'd1);
    check("beq0.ex.rw", 32'(RegWrite), 32'd0);
    @(posedge clock);
    #1;

    // bne taken (Zero=0)
    Opcode = 6'b000101;
    cyc("bne.if", 3'd0, O_FETCH);
    cyc("bne.id", 3'd1, 19'd0);
    cyc("bne.ex", 3'd2, O_AOP_B | O_PCW | O_SRC_BR);

    // lw to I/O, never ready: times out on the fourth IOW cycle
    Opcode = 6'b100011;
    Alu_resultHigh = 22'h3FFFFF;
    cyc("lwto.if", 3'd0, O_FETCH);
    cyc("lwto.id", 3'd1, 19'd0);
    cyc("lwto.ex", 3'd2, O_ASRC);
    cyc("lwto.mem", 3'd3, 19'd0);
    cyc("lwto.iow1", 3'd5, O_IOR);
    cyc("lwto.iow2", 3'd5, O_IOR);
    cyc("lwto.iow3", 3'd5, O_IOR);
    cyc("lwto.iow4", 3'd5, O_IOR | O_ILL);

    // sw to I/O with ready on the timeout cycle: ready wins
    Opcode = 6'b101011;
    cyc("swtr.if", 3'd0, O_FETCH);
    cyc("swtr.id", 3'd1, 19'd0);
    cyc("swtr.ex", 3'd2, O_ASRC);
    cyc("swtr.mem", 3'd3, 19'd0);
    cyc("swtr.iow1", 3'd5, O_IOW);
    cyc("swtr.iow2", 3'd5, O_IOW);
    cyc("swtr.iow3", 3'd5, O_IOW);
    io_ready = 1'b1;
    cyc("swtr.iow4", 3'd5, O_IOW);
    io_ready = 1'b0;

    // lw from I/O with ready on the first IOW cycle, then write-back
    Opcode = 6'b100011;
    io_ready = 1'b1;
    cyc("lwio.if", 3'd0, O_FETCH);
    cyc("lwio.id", 3'd1, 19'd0);
    cyc("lwio.ex", 3'd2, O_ASRC);
    cyc("lwio.mem", 3'd3, 19'd0);
    cyc("lwio.iow", 3'd5, O_IOR);
    io_ready = 1'b0;
    cyc("lwio.wb", 3'd4, O_RW | O_M2R);

    // illegal opcode
    Opcode = 6'b111111;
    cyc("bad.if", 3'd0, O_FETCH);
    cyc("bad.id", 3'd1, O_ILL);

    // j and jr
    Opcode = 6'b000010;
    cyc("j.if", 3'd0, O_FETCH);
    cyc("j.id", 3'd1, O_PCW | O_SRC_J | O_JMP);
    Opcode = 6'b000000;
    Function_opcode = 6'b001000;
    cyc("jr.if", 3'd0, O_FETCH);
    cyc("jr.id", 3'd1, O_PCW | O_SRC_JR | O_JR);

    // reset in the middle of an I/O read
    Opcode = 6'b100011;
    cyc("rio.if", 3'd0, O_FETCH);
    cyc("rio.id", 3'd1, 19'd0);
    cyc("rio.ex", 3'd2, O_ASRC);
    cyc("rio.mem", 3'd3, 19'd0);
    cyc("rio.iow1", 3'd5, O_IOR);
    #1;
    check("rio.pre.ior", 32'(IORead), 32'd1);
    reset = 1'b1;
    #1;
    check("rio.rst.ior", 32'(IORead), 32'd0);
    check("rio.rst.st", 32'(state), 32'd0);
    check("rio.rst.o", 32'(outs), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    Opcode = 6'b000011;
    cyc("rio.if2", 3'd0, O_FETCH);
    cyc("jal.id", 3'd1, O_PCW | O_SRC_J | O_RW | O_JAL);
    cyc("jal.if", 3'd0, O_FETCH);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
